// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4-full slave in front of a byte-lane RAM.
// The write and read channels each have their own FSM, and the two run concurrently.
// Supported: FIXED/INCR/WRAP bursts, narrow transfers (lanes chosen by WSTRB), and ID echo on B and R.
// An out-of-range beat drops its write and returns zero read data.
// Optional: define AXI4_MEM_DECERR_EN to return DECERR (2'b11) for out-of-range beats.
module axi4_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int MEMORY_WORDS       = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWLOCK,
  input  logic [3:0]                      S_AXI_AWCACHE,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic [3:0]                      S_AXI_AWQOS,
  input  logic [3:0]                      S_AXI_AWREGION,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARLOCK,
  input  logic [3:0]                      S_AXI_ARCACHE,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic [3:0]                      S_AXI_ARQOS,
  input  logic [3:0]                      S_AXI_ARREGION,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int AW        = C_S_AXI_ADDR_WIDTH;
  localparam int IW        = C_S_AXI_ID_WIDTH;
  localparam int STRB_W    = C_S_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB  = $clog2(STRB_W);
  localparam int WORD_BITS = $clog2(MEMORY_WORDS);
  localparam int unsigned MEM_BYTES = MEMORY_WORDS * STRB_W;
`ifdef AXI4_MEM_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // Sideband signals have no effect on this memory
  logic unused_sideband;
  assign unused_sideband = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
                             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION};

  // Address of the next beat; size has already been clamped to the bus width
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
    logic [AW-1:0] bytes, incr, wrap_mask;
    bytes     = AW'(1) << size;
    incr      = (addr & ~(bytes - AW'(1))) + bytes;
    wrap_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default: next_addr = incr;
    endcase
  endfunction

  function automatic logic [2:0] eff_size(input logic [2:0] size);
    eff_size = (int'(size) > ADDR_LSB) ? 3'(ADDR_LSB) : size;
  endfunction

  function automatic logic out_of_range(input logic [AW-1:0] addr);
    out_of_range = 32'(addr) >= MEM_BYTES;
  endfunction

  // ---------------- write channel ----------------
  w_state_t w_state_reg, w_state_next;
  logic awready_reg, wready_reg, bvalid_reg;
  logic awready_next, wready_next, bvalid_next;
  logic [AW-1:0] wr_addr_reg;
  logic [7:0]    wr_len_reg, wr_cnt_reg;
  logic [2:0]    wr_size_reg;
  logic [1:0]    wr_burst_reg, bresp_reg, bresp_final;
  logic          wr_err_reg, wr_dec_reg;
  logic [IW-1:0] bid_reg;
  logic aw_hs, w_hs, b_hs, w_last_beat, beat_err, beat_oor;

  assign aw_hs       = S_AXI_AWVALID && awready_reg;
  assign w_hs        = S_AXI_WVALID && wready_reg;
  assign b_hs        = bvalid_reg && S_AXI_BREADY;
  assign w_last_beat = (wr_cnt_reg == wr_len_reg);
  assign beat_err    = (S_AXI_WLAST != w_last_beat);
  assign beat_oor    = out_of_range(wr_addr_reg);

  // Write FSM state and registered handshake outputs
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
    end
  end

  // Write FSM next-state
  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (aw_hs) w_state_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_next = W_RESP;
      W_RESP:  if (b_hs) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write FSM outputs, decoded from the state being entered
  always_comb begin
    awready_next = (w_state_next == W_IDLE);
    wready_next  = (w_state_next == W_DATA);
    bvalid_next  = (w_state_next == W_RESP);
  end

  // Final response includes the beat being accepted; DECERR outranks SLVERR
  always_comb begin
    bresp_final = 2'b00;
    if (DECERR_EN && (wr_dec_reg || beat_oor))
      bresp_final = 2'b11;
    else if (wr_err_reg || beat_err)
      bresp_final = 2'b10;
  end

  // Write burst tracking: capture on AW, advance per W beat
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_addr_reg  <= '0;
      wr_len_reg   <= '0;
      wr_cnt_reg   <= '0;
      wr_size_reg  <= '0;
      wr_burst_reg <= '0;
      wr_err_reg   <= 1'b0;
      wr_dec_reg   <= 1'b0;
      bid_reg      <= '0;
      bresp_reg    <= '0;
    end else if (aw_hs) begin
      wr_addr_reg  <= S_AXI_AWADDR;
      wr_len_reg   <= S_AXI_AWLEN;
      wr_cnt_reg   <= '0;
      wr_size_reg  <= eff_size(S_AXI_AWSIZE);
      wr_burst_reg <= S_AXI_AWBURST;
      wr_err_reg   <= 1'b0;
      wr_dec_reg   <= 1'b0;
      bid_reg      <= S_AXI_AWID;
    end else if (w_hs) begin
      wr_addr_reg <= next_addr(wr_addr_reg, wr_size_reg, wr_len_reg, wr_burst_reg);
      wr_cnt_reg  <= wr_cnt_reg + 8'd1;
      wr_err_reg  <= wr_err_reg | beat_err;
      wr_dec_reg  <= wr_dec_reg | beat_oor;
      if (w_last_beat) bresp_reg <= bresp_final;
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BID     = bid_reg;
  assign S_AXI_BRESP   = bresp_reg;

  // ---------------- read channel ----------------
  r_state_t r_state_reg, r_state_next;
  logic arready_reg, rvalid_reg, arready_next, rvalid_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_adv, rd_addr_sel;
  logic [7:0]    rd_len_reg, rd_cnt_reg;
  logic [2:0]    rd_size_reg;
  logic [1:0]    rd_burst_reg;
  logic          rd_oor_reg;
  logic [IW-1:0] rid_reg;
  logic ar_hs, r_hs, r_last_beat, ram_re;

  assign ar_hs       = S_AXI_ARVALID && arready_reg;
  assign r_hs        = rvalid_reg && S_AXI_RREADY;
  assign r_last_beat = (rd_cnt_reg == rd_len_reg);
  assign rd_addr_adv = next_addr(rd_addr_reg, rd_size_reg, rd_len_reg, rd_burst_reg);
  // First word is fetched in R_FETCH; each accepted non-last beat prefetches the next one
  assign ram_re      = (r_state_reg == R_FETCH) || (r_hs && !r_last_beat);
  assign rd_addr_sel = (r_state_reg == R_FETCH) ? rd_addr_reg : rd_addr_adv;

  // Read FSM state and registered handshake outputs
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
    end
  end

  // Read FSM next-state
  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_FETCH;
      R_FETCH: r_state_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read FSM outputs, decoded from the state being entered
  always_comb begin
    arready_next = (r_state_next == R_IDLE);
    rvalid_next  = (r_state_next == R_DATA);
  end

  // Read burst tracking: capture on AR, advance on each accepted beat
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_addr_reg  <= '0;
      rd_len_reg   <= '0;
      rd_cnt_reg   <= '0;
      rd_size_reg  <= '0;
      rd_burst_reg <= '0;
      rd_oor_reg   <= 1'b0;
      rid_reg      <= '0;
    end else begin
      if (ar_hs) begin
        rd_addr_reg  <= S_AXI_ARADDR;
        rd_len_reg   <= S_AXI_ARLEN;
        rd_cnt_reg   <= '0;
        rd_size_reg  <= eff_size(S_AXI_ARSIZE);
        rd_burst_reg <= S_AXI_ARBURST;
        rid_reg      <= S_AXI_ARID;
      end else if (r_hs && !r_last_beat) begin
        rd_addr_reg <= rd_addr_adv;
        rd_cnt_reg  <= rd_cnt_reg + 8'd1;
      end
      if (ram_re) rd_oor_reg <= out_of_range(rd_addr_sel);
    end
  end

  // ---------------- byte-lane RAM ----------------
  logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;
  logic                          ram_we;
  logic [WORD_BITS-1:0]          ram_waddr, ram_raddr;

  assign ram_we    = w_hs && !beat_oor;
  assign ram_waddr = wr_addr_reg[ADDR_LSB +: WORD_BITS];
  assign ram_raddr = rd_addr_sel[ADDR_LSB +: WORD_BITS];

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    logic [7:0] lane_mem [MEMORY_WORDS];
    logic [7:0] lane_rd_reg;
    // One byte lane: strobed write, enabled registered read (old data on collision)
    always_ff @(posedge S_AXI_ACLK) begin
      if (ram_we && S_AXI_WSTRB[gi]) lane_mem[ram_waddr] <= S_AXI_WDATA[8*gi +: 8];
      if (ram_re) lane_rd_reg <= lane_mem[ram_raddr];
    end
    assign ram_rdata[8*gi +: 8] = lane_rd_reg;
  end

  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RID     = rid_reg;
  assign S_AXI_RLAST   = rvalid_reg && r_last_beat;
  assign S_AXI_RDATA   = (rvalid_reg && !rd_oor_reg) ? ram_rdata : '0;
  assign S_AXI_RRESP   = (DECERR_EN && rvalid_reg && rd_oor_reg) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: directed bench for axi4_mem_slave with a 32-bit bus and 1024 words.
// Every expected value below is a hand-computed constant.
module tb_axi4_mem_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  AWID = '0, ARID = '0, BID, RID;
  logic [15:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = '0, ARSIZE = '0;
  logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic        AWVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
  logic [31:0] WDATA = '0, RDATA;
  logic [3:0]  WSTRB = '0;

  int check_cnt = 0;
  int err_cnt = 0;
  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];

`ifdef AXI4_MEM_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  always #5 clk = ~clk;

  axi4_mem_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
    .S_AXI_AWBURST(AWBURST), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
    .S_AXI_AWQOS(4'd0), .S_AXI_AWREGION(4'd0), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
    .S_AXI_WREADY(WREADY), .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID),
    .S_AXI_BREADY(BREADY),
    .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(ARSIZE),
    .S_AXI_ARBURST(ARBURST), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
    .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    bit rdy;
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
    do begin rdy = AWREADY; tick(); n++; end while (!rdy && n < 100);
    AWVALID = 1'b0;
    check("aw_handshake", rdy, 1);
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit rdy;
    int n = 0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    do begin rdy = WREADY; tick(); n++; end while (!rdy && n < 100);
    WVALID = 1'b0; WLAST = 1'b0;
    check("w_handshake", rdy, 1);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    bit rdy;
    int n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    do begin rdy = ARREADY; tick(); n++; end while (!rdy && n < 100);
    ARVALID = 1'b0;
    check("ar_handshake", rdy, 1);
  endtask

  // Full write burst from wbuf; wlast_at < 0 puts WLAST on the true last beat
  task automatic wr_burst(input logic [3:0] id, input logic [15:0] addr, input int len,
                          input logic [1:0] burst, input logic [3:0] strb, input int wlast_at,
                          input int hold, input logic [1:0] exp_resp);
    int n = 0;
    logic [1:0] resp;
    logic [3:0] bid;
    aw_send(id, addr, 8'(len), burst);
    for (int i = 0; i <= len; i++)
      w_beat(wbuf[i], strb, (wlast_at < 0) ? (i == len) : (i == wlast_at));
    while (!BVALID && n < 100) begin tick(); n++; end
    check("b_valid", BVALID, 1);
    for (int k = 0; k < hold; k++) begin
      check("b_hold_valid", BVALID, 1);
      check("b_hold_id", BID, id);
      tick();
    end
    BREADY = 1'b1;
    resp = BRESP;
    bid = BID;
    tick();
    BREADY = 1'b0;
    check("b_clear", BVALID, 0);
    check("bresp", resp, exp_resp);
    check("bid", bid, id);
    $display("WR id=%0d addr=0x%04h len=%0d strb=0x%0h bresp=%0d bid=%0d", id, addr, len, strb, resp, bid);
  endtask

  // Full read burst compared against ebuf; toggle stalls RREADY every other cycle
  task automatic rd_burst(input logic [3:0] id, input logic [15:0] addr, input int len,
                          input logic [1:0] burst, input bit toggle, input logic [1:0] exp_resp);
    int t = 0;
    int n = 0;
    int lat = -1;
    bit stalled = 0;
    logic [31:0] sd = '0;
    logic [31:0] rbuf [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    ar_send(id, addr, 8'(len), burst);
    while (n <= len && t < 200) begin
      if (lat < 0 && RVALID) lat = t;
      if (stalled) begin
        check("r_stall_valid", RVALID, 1);
        check("r_stall_data", RDATA, sd);
      end
      stalled = 0;
      RREADY = toggle ? (t % 2 == 0) : 1'b1;
      if (RVALID && RREADY) begin
        rbuf[n] = RDATA; rrsp[n] = RRESP; rlst[n] = RLAST;
        check("rid", RID, id);
        n++;
      end else if (RVALID) begin
        stalled = 1;
        sd = RDATA;
      end
      tick();
      t++;
    end
    RREADY = 1'b0;
    check("r_beats", n, len + 1);
    check("r_latency", lat, 1);
    for (int i = 0; i < n; i++) begin
      check("rdata", rbuf[i], ebuf[i]);
      check("rlast", rlst[i], (i == len));
      check("rresp", rrsp[i], exp_resp);
    end
    $display("RD id=%0d addr=0x%04h len=%0d burst=%0d beats=%0d first=0x%08h", id, addr, len, burst, n, rbuf[0]);
  endtask

  task automatic check_outputs_zero(input string phase);
    check({phase, "_awready"}, AWREADY, 0);
    check({phase, "_wready"}, WREADY, 0);
    check({phase, "_bvalid"}, BVALID, 0);
    check({phase, "_arready"}, ARREADY, 0);
    check({phase, "_rvalid"}, RVALID, 0);
    check({phase, "_rlast"}, RLAST, 0);
    check({phase, "_bresp"}, BRESP, 0);
    check({phase, "_rresp"}, RRESP, 0);
    check({phase, "_bid"}, BID, 0);
    check({phase, "_rid"}, RID, 0);
    check({phase, "_rdata"}, RDATA, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick(); tick();
    check("idle_awready", AWREADY, 1);
    check("idle_arready", ARREADY, 1);

    // INCR write then read back
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    wr_burst(4'd5, 16'h0010, 3, 2'b01, 4'hF, -1, 0, 2'b00);
    for (int i = 0; i < 4; i++) ebuf[i] = wbuf[i];
    rd_burst(4'd9, 16'h0010, 3, 2'b01, 1'b0, 2'b00);

    // WRAP len=3 from 0x18 wraps within 0x10..0x1F
    ebuf[0] = 32'h33333333; ebuf[1] = 32'h44444444; ebuf[2] = 32'h11111111; ebuf[3] = 32'h22222222;
    rd_burst(4'd2, 16'h0018, 3, 2'b10, 1'b0, 2'b00);

    // FIXED read returns the same word each beat
    wbuf[0] = 32'hCAFEF00D;
    wr_burst(4'd1, 16'h0004, 0, 2'b01, 4'hF, -1, 0, 2'b00);
    for (int i = 0; i < 3; i++) ebuf[i] = 32'hCAFEF00D;
    rd_burst(4'd3, 16'h0004, 2, 2'b00, 1'b0, 2'b00);

    // Strobed write over zero
    wbuf[0] = 32'h00000000;
    wr_burst(4'd1, 16'h0000, 0, 2'b01, 4'hF, -1, 0, 2'b00);
    wbuf[0] = 32'hAABBCCDD;
    wr_burst(4'd1, 16'h0000, 0, 2'b01, 4'b0101, -1, 0, 2'b00);
    ebuf[0] = 32'h00BB00DD;
    rd_burst(4'd4, 16'h0000, 0, 2'b01, 1'b0, 2'b00);

    // Early WLAST gives SLVERR
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h0000A000 + i;
    wr_burst(4'd6, 16'h0040, 3, 2'b01, 4'hF, 1, 0, 2'b10);

    // Concurrent write (BREADY held low 5 cycles) and read (RREADY toggling)
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h80000000 + i;
    ebuf[0] = 32'h11111111; ebuf[1] = 32'h22222222; ebuf[2] = 32'h33333333; ebuf[3] = 32'h44444444;
    fork
      wr_burst(4'd7, 16'h0080, 7, 2'b01, 4'hF, -1, 5, 2'b00);
      rd_burst(4'd8, 16'h0010, 3, 2'b01, 1'b1, 2'b00);
    join
    for (int i = 0; i < 8; i++) ebuf[i] = 32'h80000000 + i;
    rd_burst(4'd8, 16'h0080, 7, 2'b01, 1'b1, 2'b00);

    // Out-of-range: zero read, dropped write (0x1000 aliases word 0)
    ebuf[0] = 32'h0;
    rd_burst(4'd10, 16'h1000, 0, 2'b01, 1'b0, OOR_RESP);
    wbuf[0] = 32'hDEADBEEF;
    wr_burst(4'd11, 16'h1000, 0, 2'b01, 4'hF, -1, 0, OOR_RESP);
    ebuf[0] = 32'h00BB00DD;
    rd_burst(4'd12, 16'h0000, 0, 2'b01, 1'b0, 2'b00);

    // Reset in the middle of a write burst
    aw_send(4'd13, 16'h0100, 8'd3, 2'b01);
    w_beat(32'hFFFFFFFF, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    $display("RST asserted mid-write burst");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_reset_awready", AWREADY, 1);
    wbuf[0] = 32'h5555AAAA; wbuf[1] = 32'h12345678;
    wr_burst(4'd14, 16'h0100, 1, 2'b01, 4'hF, -1, 0, 2'b00);
    ebuf[0] = 32'h5555AAAA; ebuf[1] = 32'h12345678;
    rd_burst(4'd15, 16'h0100, 1, 2'b01, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end
endmodule
